// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, fetch FSM encoding, NOP encoding and
// the sequential-PC helper used by the fetch stage.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FETCH_RUN    = 2'b00,
        FETCH_DRAIN  = 2'b01,
        FETCH_HALTED = 2'b10
    } fetch_state_t;

    // All-zero word is SLL $0,$0,0: the canonical bubble instruction.
    localparam word_t NOP_INSTR = 32'h0000_0000;

    localparam word_t PC_STEP = 32'h0000_0004;

    // Sequential successor of a PC; wraps modulo 2^32 with no flag.
    function automatic word_t pc_next(input word_t pc);
        return pc + PC_STEP;
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bundle between fetch and the icache.
interface fetch_stage_if
    import cpu_types_pkg::*;
();

    logic  ihit;
    word_t imemload;
    logic  imemREN;
    word_t imemaddr;

    // Fetch side: issues the read, consumes the returned word.
    modport master (
        input  ihit,
        input  imemload,
        output imemREN,
        output imemaddr
    );

    // Cache side: serves the read.
    modport slave (
        output ihit,
        output imemload,
        input  imemREN,
        input  imemaddr
    );

endinterface

// File: rtl/fetch_stage_ifid_reg.sv
// IF/ID pipeline latch: load captures a fetched instruction, bubble
// writes a NOP with valid cleared, neither holds. Bubble wins over load.
module ifid_reg
    import cpu_types_pkg::*;
(
    input  logic  CLK,
    input  logic  nRST,
    input  logic  load_i,
    input  logic  bubble_i,
    input  word_t instr_i,
    input  word_t pc_i,
    input  word_t npc_i,
    output word_t instr_o,
    output word_t pc_o,
    output word_t npc_o,
    output logic  valid_o
);

    word_t instr_q, instr_d;
    word_t pc_q,    pc_d;
    word_t npc_q,   npc_d;
    logic  valid_q, valid_d;

    // Select next latch contents: bubble, new instruction, or hold.
    always_comb begin
        instr_d = instr_q;
        pc_d    = pc_q;
        npc_d   = npc_q;
        valid_d = valid_q;
        if (bubble_i) begin
            instr_d = NOP_INSTR;
            pc_d    = 32'h0000_0000;
            npc_d   = 32'h0000_0000;
            valid_d = 1'b0;
        end else if (load_i) begin
            instr_d = instr_i;
            pc_d    = pc_i;
            npc_d   = npc_i;
            valid_d = 1'b1;
        end else begin
            instr_d = instr_q;
            pc_d    = pc_q;
            npc_d   = npc_q;
            valid_d = valid_q;
        end
    end

    // Latch register with synchronous active-low reset to an empty slot.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            instr_q <= NOP_INSTR;
            pc_q    <= 32'h0000_0000;
            npc_q   <= 32'h0000_0000;
            valid_q <= 1'b0;
        end else begin
            instr_q <= instr_d;
            pc_q    <= pc_d;
            npc_q   <= npc_d;
            valid_q <= valid_d;
        end
    end

    assign instr_o = instr_q;
    assign pc_o    = pc_q;
    assign npc_o   = npc_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives icache reads, and fills the
// IF/ID latch. Handles stalls, redirects (including redirects that land
// while a miss is outstanding) and a sticky halt that only reset clears.
module fetch_stage
    import cpu_types_pkg::*;
#(
    parameter word_t PC_INIT = 32'h0000_0000
)(
    input  logic          CLK,
    input  logic          nRST,
    fetch_stage_if.master imem,
    input  logic          stall,
    input  logic          redirect,
    input  word_t         redirect_pc,
    input  logic          halt,
    output word_t         ifid_instr,
    output word_t         ifid_pc,
    output word_t         ifid_npc,
    output logic          ifid_valid
);

    fetch_state_t state_q, state_d;
    word_t        pc_q,    pc_d;
    word_t        pend_q,  pend_d;
    logic         load_s;
    logic         bubble_s;

    // Address and request come straight from registers so the cache sees
    // a stable address for the whole miss, including during DRAIN.
    assign imem.imemaddr = pc_q;
    assign imem.imemREN  = (state_q != FETCH_HALTED) ? 1'b1 : 1'b0;

    // Next-state, next-PC and IF/ID control decode.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        pend_d   = pend_q;
        load_s   = 1'b0;
        bubble_s = 1'b0;
        case (state_q)
            FETCH_RUN: begin
                if (redirect) begin
                    bubble_s = 1'b1;
                    if (imem.ihit) begin
                        pc_d = redirect_pc;
                    end else begin
                        // Miss in flight: park the target, keep the address.
                        pend_d  = redirect_pc;
                        state_d = FETCH_DRAIN;
                    end
                end else if (halt) begin
                    bubble_s = 1'b1;
                    state_d  = FETCH_HALTED;
                end else if (stall) begin
                    // Hold PC and IF/ID; a hit this cycle is refetched later.
                    load_s = 1'b0;
                end else if (imem.ihit) begin
                    load_s = 1'b1;
                    pc_d   = pc_next(pc_q);
                end else begin
                    bubble_s = 1'b1;
                end
            end
            FETCH_DRAIN: begin
                // Waiting out the stale miss; its data is thrown away.
                bubble_s = 1'b1;
                if (redirect) begin
                    pend_d = redirect_pc;
                end else begin
                    pend_d = pend_q;
                end
                if (imem.ihit) begin
                    pc_d    = redirect ? redirect_pc : pend_q;
                    state_d = FETCH_RUN;
                end else begin
                    pc_d = pc_q;
                end
            end
            FETCH_HALTED: begin
                bubble_s = 1'b1;
            end
            default: begin
                bubble_s = 1'b1;
                state_d  = FETCH_RUN;
            end
        endcase
    end

    // PC, pending-target and FSM state registers.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q <= FETCH_RUN;
            pc_q    <= PC_INIT;
            pend_q  <= 32'h0000_0000;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pend_q  <= pend_d;
        end
    end

    ifid_reg u_ifid_reg (
        .CLK      (CLK),
        .nRST     (nRST),
        .load_i   (load_s),
        .bubble_i (bubble_s),
        .instr_i  (imem.imemload),
        .pc_i     (pc_q),
        .npc_i    (pc_next(pc_q)),
        .instr_o  (ifid_instr),
        .pc_o     (ifid_pc),
        .npc_o    (ifid_npc),
        .valid_o  (ifid_valid)
    );

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the pipelined MIPS core, directly upstream of decode and the control unit. It owns the PC, issues instruction reads to the icache via a REN/hit handshake, and drives the IF/ID pipeline register whose `ifid_instr` is decoded by the control unit. It supports hazard stalls, branch/jump redirects, redirects that arrive during an icache miss, and a sticky halt.

## Interface
- `PC_INIT`, default `32'h0000_0000`: PC value loaded on reset.

Ports:
- `CLK`  in  1  sole clock; all state updates on rising edge.
- `nRST`  in  1  reset, synchronous, active-low.
- `ihit`  in  1  icache has returned `imemload` for `imemaddr` this cycle.
- `imemload`  in  32  instruction word (`word_t`).
- `imemREN`  out  1  instruction read request.
- `imemaddr`  out  32  fetch address.
- `stall`  in  1  hazard unit holds IF/ID and PC.
- `redirect`  in  1  branch taken, J, JAL or JR resolved downstream; flush and refetch.
- `redirect_pc`  in  32  redirect target, valid when `redirect`=1.
- `halt`  in  1  decode has seen HALT (`cuHALT`) in `ifid_instr`.
- `ifid_instr`  out  32  fetched instruction; `32'h0` (NOP) when bubble.
- `ifid_pc`  out  32  PC of `ifid_instr`.
- `ifid_npc`  out  32  `ifid_pc + 4`.
- `ifid_valid`  out  1  IF/ID holds a real instruction.

## Operation
- Registers: `pc`, `state`, `pend_pc`, IF/ID fields. `imemaddr = pc`, combinational from register.
- `imemREN` = 1 in RUN and DRAIN, 0 in HALTED.
- Reset (nRST=0 at edge): `pc`=PC_INIT, state=RUN, `pend_pc`=0, `ifid_instr/pc/npc`=0, `ifid_valid`=0.
- States: RUN, DRAIN, HALTED. Priority in RUN is redirect > halt > stall > normal.
- RUN, `redirect`=1, `ihit`=1: `pc`←`redirect_pc`; IF/ID←bubble; discard `imemload`; stay RUN.
- RUN, `redirect`=1, `ihit`=0: the miss is outstanding, so `imemaddr` must not change. `pend_pc`←`redirect_pc`; IF/ID←bubble; go to DRAIN.
- RUN, `halt`=1 (no redirect): go to HALTED; IF/ID←bubble; `pc` frozen.
- RUN, `stall`=1: `pc` and IF/ID hold. An `ihit` in that cycle is ignored and the address is refetched later.
- RUN, `ihit`=1: IF/ID←{`imemload`, `pc`, `pc+4`, valid=1}; `pc`←`pc+4`.
- RUN, `ihit`=0: IF/ID←bubble; `pc` holds.
- DRAIN: `imemaddr` = old `pc`. IF/ID holds bubble regardless of `stall`.
  - A further `redirect` overwrites `pend_pc`.
  - On `ihit`: discard data, `pc`←`pend_pc` (or `redirect_pc` if `redirect` is also 1 that cycle), go to RUN.
  - `halt` is ignored.
- HALTED: all inputs ignored; IF/ID bubble; exit only via reset.
- PC arithmetic is 32-bit modulo. `32'hFFFF_FFFC`+4 wraps to 0 with no flag. Low two bits of targets are passed unmodified.

## Timing
- Fetch latency: an instruction at `pc` appears on `ifid_instr` the edge after the cycle `ihit`=1. With ihit every cycle, throughput is one instruction per cycle.
- Redirect penalty on a hit: the next edge loads bubble and `pc`=target. The target instruction appears in IF/ID one cycle after the target is hit.
- Redirect during a miss: the target is fetched starting the cycle after the draining `ihit`.
- `halt` is seen in the cycle `ifid_instr`=HALT. IF/ID is bubbled on the next edge; decode latches HALT into ID/EX on that same edge.
- `imemREN` falls in the first HALTED cycle.
- Reset mid-DRAIN or mid-miss: the state is abandoned, and fetch restarts at PC_INIT with `imemREN`=1 on the first cycle after reset.

## Structure
- `cpu_types_pkg`: add `typedef enum logic [1:0] {FETCH_RUN, FETCH_DRAIN, FETCH_HALTED} fetch_state_t`. Reuse `word_t`.
- Add `localparam word_t NOP_INSTR = '0` to the same package; decode uses it too.
- Sub-module `ifid_reg`: holds the IF/ID fields with `load` and `bubble` controls and synchronous active-low reset; it is reused by the ID/EX latch pattern.
- `fetch_stage` holds the PC, pending target and the FSM.

## Test plan
- Reset then `ihit`=1 every cycle with `imemload`=0x24010001, 0x24020002, 0x00221821. Required: `ifid_pc` = 0, 4, 8 on consecutive cycles, with `ifid_npc` = `ifid_pc`+4 and valid=1.
- Stall for 2 cycles at `pc`=8 with `ihit`=1. Required: IF/ID holds the 0x4 instruction and `imemaddr` stays 8; after release the 0x8 instruction loads.
- `redirect`=1, `redirect_pc`=0x40 with `ihit`=1 at `pc`=0xC. Required: next cycle is bubble (instr 0, valid 0) and `imemaddr`=0x40; the 0x40 instruction is in IF/ID one cycle later.
- `ihit`=0 at `pc`=0x10, `redirect` to 0x80 held 3 cycles, then `ihit`=1. Required: `imemaddr` stays 0x10 throughout DRAIN; the data returned is discarded; `imemaddr`=0x80 next.
- `halt`=1 when `ifid_instr`=0xFC000000. Required: next cycle bubble and `imemREN`=0; `pc`, `imemaddr` and IF/ID stay frozen for 10 cycles despite `ihit`/`redirect`; `nRST`=0 then restores `pc`=PC_INIT.
- `redirect` and `halt` in the same cycle. Required: redirect wins and the state stays RUN; `pc` starting at `32'hFFFF_FFFC` wraps to 0 after a hit.
